// File: rtl/rx_byte_fifo.sv
`default_nettype none
// ============================================================================
// rx_byte_fifo : receive-side byte FIFO with fill-level flags and sticky errors
// Revision 1.0
// ============================================================================
module rx_byte_fifo #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 3,
   parameter int AF_THRESH  = 6,
   parameter int AE_THRESH  = 2
) (
   input  logic                  clk_4f,
   input  logic                  reset,
   input  logic                  active,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic                  valid_in,
   input  logic                  pop,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  valid_out,
   output logic [ADDR_WIDTH:0]   count,
   output logic                  fifo_empty,
   output logic                  fifo_full,
   output logic                  almost_full,
   output logic                  almost_empty,
   output logic                  overflow_err,
   output logic                  underflow_err
);

   localparam int DEPTH = 1 << ADDR_WIDTH;
   localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(DEPTH);
   localparam logic [ADDR_WIDTH:0] AF_C    = (ADDR_WIDTH+1)'(AF_THRESH);
   localparam logic [ADDR_WIDTH:0] AE_C    = (ADDR_WIDTH+1)'(AE_THRESH);

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [ADDR_WIDTH-1:0] wr_ptr;
   logic [ADDR_WIDTH-1:0] rd_ptr;
   logic                  push;
   logic                  push_ok;
   logic                  pop_ok;

   assign fifo_empty   = (count == '0);
   assign fifo_full    = (count == DEPTH_C);
   assign almost_full  = (count >= AF_C);
   assign almost_empty = (count <= AE_C);

   // A pop frees a slot in the same cycle, so a full FIFO still accepts a push alongside it.
   assign push    = valid_in & active;
   assign pop_ok  = pop & ~fifo_empty;
   assign push_ok = push & (~fifo_full | pop_ok);

   always_ff @(posedge clk_4f) begin
      if (!reset && push_ok) begin
         mem[wr_ptr] <= data_in;
      end
   end

   always_ff @(posedge clk_4f) begin
      if (reset) begin
         wr_ptr        <= '0;
         rd_ptr        <= '0;
         count         <= '0;
         data_out      <= '0;
         valid_out     <= 1'b0;
         overflow_err  <= 1'b0;
         underflow_err <= 1'b0;
      end else begin
         valid_out <= pop_ok;
         if (push_ok) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop_ok) begin
            data_out <= mem[rd_ptr];
            rd_ptr   <= rd_ptr + 1'b1;
         end
         case ({push_ok, pop_ok})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         if (push && !push_ok) begin
            overflow_err <= 1'b1;
         end
         if (pop && fifo_empty) begin
            underflow_err <= 1'b1;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_rx_byte_fifo.sv
`default_nettype none
// ============================================================================
// tb_rx_byte_fifo : scoreboard bench for rx_byte_fifo
// Revision 1.0
// ============================================================================
module tb_rx_byte_fifo;

   logic       clk_4f = 1'b0;
   logic       reset = 1'b1;
   logic       active = 1'b0;
   logic [7:0] data_in = 8'h00;
   logic       valid_in = 1'b0;
   logic       pop = 1'b0;
   logic [7:0] data_out;
   logic       valid_out;
   logic [3:0] count;
   logic       fifo_empty, fifo_full, almost_full, almost_empty;
   logic       overflow_err, underflow_err;

   int npass = 0;
   int ntotal = 0;

   // reference model: queue holds the bytes the FIFO should currently contain
   logic [7:0] mq[$];
   logic [7:0] exp_data = 8'h00;
   logic       exp_valid = 1'b0;
   logic       exp_ovf = 1'b0;
   logic       exp_unf = 1'b0;

   rx_byte_fifo dut (
      .clk_4f(clk_4f), .reset(reset), .active(active), .data_in(data_in),
      .valid_in(valid_in), .pop(pop), .data_out(data_out), .valid_out(valid_out),
      .count(count), .fifo_empty(fifo_empty), .fifo_full(fifo_full),
      .almost_full(almost_full), .almost_empty(almost_empty),
      .overflow_err(overflow_err), .underflow_err(underflow_err)
   );

   always #5 clk_4f = ~clk_4f;

   task automatic do_reset(input int n);
      reset = 1'b1; valid_in = 1'b0; pop = 1'b0; active = 1'b0;
      repeat (n) @(posedge clk_4f);
      #1;
      reset = 1'b0;
      mq.delete();
      exp_data = 8'h00; exp_valid = 1'b0; exp_ovf = 1'b0; exp_unf = 1'b0;
   endtask

   // One clock: drive inputs, advance one edge, update the model.
   task automatic drive(input logic v, input logic a, input logic [7:0] d, input logic p);
      bit m_full, m_empty, pok, wok;
      valid_in = v; active = a; data_in = d; pop = p;
      m_full  = (mq.size() == 8);
      m_empty = (mq.size() == 0);
      pok = p && !m_empty;
      wok = v && a && (!m_full || pok);
      @(posedge clk_4f);
      #1;
      exp_valid = pok;
      if (pok) exp_data = mq.pop_front();
      if (wok) mq.push_back(d);
      if (v && a && !wok) exp_ovf = 1'b1;
      if (p && m_empty) exp_unf = 1'b1;
      valid_in = 1'b0; pop = 1'b0;
   endtask

   task automatic test_reset();
      do_reset(2);
      ntotal++;
      if (count !== 4'd0 || fifo_empty !== 1'b1 || almost_empty !== 1'b1 ||
          fifo_full !== 1'b0 || almost_full !== 1'b0)
         $display("FAIL reset_flags: count=%0d e=%b ae=%b f=%b af=%b, want 0 1 1 0 0",
                  count, fifo_empty, almost_empty, fifo_full, almost_full);
      else npass++;
      ntotal++;
      if (valid_out !== 1'b0 || data_out !== 8'h00 || overflow_err !== 1'b0 || underflow_err !== 1'b0)
         $display("FAIL reset_out: v=%b d=%h ovf=%b unf=%b, want 0 00 0 0",
                  valid_out, data_out, overflow_err, underflow_err);
      else npass++;
   endtask

   task automatic test_ordering();
      logic [7:0] bytes [3] = '{8'h11, 8'h22, 8'h33};
      for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, bytes[i], 1'b0);
      ntotal++;
      if (count !== 4'd3) $display("FAIL order_count: got %0d want 3", count);
      else npass++;
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, 1'b1, 8'h00, 1'b1);
         ntotal++;
         if (valid_out !== 1'b1 || data_out !== exp_data || exp_data !== bytes[i])
            $display("FAIL order_pop%0d: got v=%b d=%h want v=1 d=%h", i, valid_out, data_out, bytes[i]);
         else npass++;
      end
      drive(1'b0, 1'b1, 8'h00, 1'b0);
      ntotal++;
      if (count !== 4'd0 || valid_out !== 1'b0 || data_out !== 8'h33)
         $display("FAIL order_idle: count=%0d v=%b d=%h want 0 0 33", count, valid_out, data_out);
      else npass++;
   endtask

   task automatic test_overflow();
      do_reset(1);
      for (int i = 1; i <= 9; i++) begin
         drive(1'b1, 1'b1, 8'(i), 1'b0);
         if (i == 8) begin
            ntotal++;
            if (fifo_full !== 1'b1 || count !== 4'd8 || overflow_err !== 1'b0)
               $display("FAIL ovf_full: f=%b count=%0d ovf=%b want 1 8 0", fifo_full, count, overflow_err);
            else npass++;
         end
      end
      ntotal++;
      if (overflow_err !== exp_ovf || exp_ovf !== 1'b1 || count !== 4'd8)
         $display("FAIL ovf_flag: ovf=%b count=%0d want 1 8", overflow_err, count);
      else npass++;
      for (int i = 1; i <= 8; i++) begin
         drive(1'b0, 1'b1, 8'h00, 1'b1);
         ntotal++;
         if (valid_out !== 1'b1 || data_out !== exp_data)
            $display("FAIL ovf_pop%0d: got v=%b d=%h want v=1 d=%h", i, valid_out, data_out, exp_data);
         else npass++;
      end
      // pointers wrapped: next byte must go through slot 0 cleanly
      drive(1'b1, 1'b1, 8'h77, 1'b0);
      drive(1'b0, 1'b1, 8'h00, 1'b1);
      ntotal++;
      if (valid_out !== 1'b1 || data_out !== 8'h77 || fifo_empty !== 1'b1 || overflow_err !== 1'b1)
         $display("FAIL ovf_wrap: v=%b d=%h e=%b ovf=%b want 1 77 1 1", valid_out, data_out, fifo_empty, overflow_err);
      else npass++;
   endtask

   task automatic test_simultaneous();
      do_reset(1);
      for (int i = 0; i < 8; i++) drive(1'b1, 1'b1, 8'hC0 + 8'(i), 1'b0);
      drive(1'b1, 1'b1, 8'hAA, 1'b1);
      ntotal++;
      if (count !== 4'd8 || overflow_err !== 1'b0 || valid_out !== 1'b1 || data_out !== 8'hC0)
         $display("FAIL sim_full: count=%0d ovf=%b v=%b d=%h want 8 0 1 c0", count, overflow_err, valid_out, data_out);
      else npass++;
      for (int i = 0; i < 8; i++) begin
         drive(1'b0, 1'b1, 8'h00, 1'b1);
         ntotal++;
         if (valid_out !== 1'b1 || data_out !== exp_data)
            $display("FAIL sim_drain%0d: got v=%b d=%h want v=1 d=%h", i, valid_out, data_out, exp_data);
         else npass++;
      end
      drive(1'b1, 1'b1, 8'h55, 1'b1);
      ntotal++;
      if (underflow_err !== 1'b1 || exp_unf !== 1'b1 || count !== 4'd1 || valid_out !== 1'b0)
         $display("FAIL sim_empty: unf=%b count=%0d v=%b want 1 1 0", underflow_err, count, valid_out);
      else npass++;
      drive(1'b0, 1'b1, 8'h00, 1'b1);
      ntotal++;
      if (valid_out !== 1'b1 || data_out !== 8'h55 || count !== 4'd0)
         $display("FAIL sim_55: v=%b d=%h count=%0d want 1 55 0", valid_out, data_out, count);
      else npass++;
   endtask

   task automatic test_gating();
      do_reset(1);
      drive(1'b1, 1'b0, 8'hEE, 1'b0);
      drive(1'b1, 1'b0, 8'hEF, 1'b0);
      ntotal++;
      if (count !== 4'd0 || overflow_err !== 1'b0)
         $display("FAIL gate_inactive: count=%0d ovf=%b want 0 0", count, overflow_err);
      else npass++;
      for (int i = 1; i <= 6; i++) begin
         drive(1'b1, 1'b1, 8'h40 + 8'(i), 1'b0);
         if (i >= 2) begin
            ntotal++;
            if (count !== 4'(mq.size()) || almost_full !== (mq.size() >= 6) ||
                almost_empty !== (mq.size() <= 2) || fifo_empty !== 1'b0)
               $display("FAIL fill_%0d: count=%0d af=%b ae=%b want af=%b ae=%b",
                        i, count, almost_full, almost_empty, mq.size() >= 6, mq.size() <= 2);
            else npass++;
         end
      end
      for (int i = 5; i >= 2; i--) begin
         drive(1'b0, 1'b1, 8'h00, 1'b1);
         ntotal++;
         if (count !== 4'(i) || almost_full !== 1'b0 || almost_empty !== (i <= 2) ||
             data_out !== exp_data || valid_out !== 1'b1)
            $display("FAIL drain_%0d: count=%0d ae=%b d=%h want count=%0d ae=%b d=%h",
                     i, count, almost_empty, data_out, i, i <= 2, exp_data);
         else npass++;
      end
      for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, 8'h90 + 8'(i), 1'b0);
      drive(1'b0, 1'b1, 8'h00, 1'b1);
      ntotal++;
      if (count !== 4'd4 || valid_out !== 1'b1)
         $display("FAIL pre_reset: count=%0d v=%b want 4 1", count, valid_out);
      else npass++;
      drive(1'b1, 1'b1, 8'h99, 1'b0);
      do_reset(1);
      ntotal++;
      if (count !== 4'd0 || fifo_empty !== 1'b1 || almost_empty !== 1'b1 || almost_full !== 1'b0 ||
          valid_out !== 1'b0 || data_out !== 8'h00)
         $display("FAIL mid_reset: count=%0d e=%b ae=%b af=%b v=%b d=%h want 0 1 1 0 0 00",
                  count, fifo_empty, almost_empty, almost_full, valid_out, data_out);
      else npass++;
      drive(1'b0, 1'b1, 8'h00, 1'b1);
      ntotal++;
      if (valid_out !== 1'b0 || underflow_err !== 1'b1)
         $display("FAIL post_reset_pop: v=%b unf=%b want 0 1", valid_out, underflow_err);
      else npass++;
   endtask

   initial begin
      test_reset();
      test_ordering();
      test_overflow();
      test_simultaneous();
      test_gating();
      $display("%0d/%0d checks passed", npass, ntotal);
      $finish;
   end

endmodule
`default_nettype wire
